// File: rtl/position_tracker_pkg.sv
// Shared types, fixed-point defaults and the clamp helper for the position tracker.
// Pure declarations: no latency, no flow control.
package tracker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_COAST   = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_HOLD   = 3'd0,
        OP_CLEAR  = 3'd1,
        OP_SNAP   = 3'd2,
        OP_FILTER = 3'd3,
        OP_EXTRAP = 3'd4
    } axis_op_t;

    localparam int DEF_INPUT_WIDTH = 11;
    localparam int DEF_FRAC_BITS   = 4;
    localparam int DEF_FIX_W       = DEF_INPUT_WIDTH + DEF_FRAC_BITS;
    localparam int CALC_W          = 32;

    function automatic logic signed [CALC_W-1:0] clamp_s(
        input logic signed [CALC_W-1:0] v,
        input logic signed [CALC_W-1:0] lo,
        input logic signed [CALC_W-1:0] hi
    );
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/position_tracker_axis_filter.sv
// One axis of the tracker: EMA filter state, velocity, gate compare and clamped extrapolation.
// State changes one cycle after op is presented; no backpressure (op is a one-shot command).
module track_axis_filter
    import tracker_pkg::*;
#(
    parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int FRAC_BITS    = DEF_FRAC_BITS,
    parameter int SMOOTH_SHIFT = 2,
    parameter int GATE_RADIUS  = 64,
    parameter int AXIS_MAX     = 640
)(
    input  logic                   clk,
    input  logic                   reset,
    input  axis_op_t               op,
    input  logic [INPUT_WIDTH-1:0] meas,
    output logic [INPUT_WIDTH-1:0] pos,
    output logic                   gated
);
    localparam int FW   = INPUT_WIDTH + FRAC_BITS;
    localparam int F_HI = (AXIS_MAX - 1) << FRAC_BITS;

    logic [FW-1:0]                f;
    logic signed [INPUT_WIDTH:0]  vel;
    logic [FW-1:0]                meas_fx;
    logic signed [FW:0]           diff;
    logic [FW-1:0]                f_filt;
    logic signed [INPUT_WIDTH:0]  vel_filt;
    logic signed [CALC_W-1:0]     f_s;
    logic signed [CALC_W-1:0]     vel_s;
    logic signed [CALC_W-1:0]     ext_sum;
    logic signed [CALC_W-1:0]     ext_clamped;
    logic signed [CALC_W-1:0]     dx;

    assign pos     = f[FW-1:FRAC_BITS];
    assign meas_fx = {meas, {FRAC_BITS{1'b0}}};
    assign diff    = $signed({1'b0, meas_fx}) - $signed({1'b0, f});
    // The shifted step always lands between f and meas_fx, so truncation back to FW is lossless.
    assign f_filt   = FW'($signed({1'b0, f}) + (diff >>> SMOOTH_SHIFT));
    assign vel_filt = $signed({1'b0, f_filt[FW-1:FRAC_BITS]}) - $signed({1'b0, pos});

    assign f_s         = $signed({{(CALC_W-FW){1'b0}}, f});
    assign vel_s       = $signed({{(CALC_W-INPUT_WIDTH-1){vel[INPUT_WIDTH]}}, vel});
    assign ext_sum     = f_s + (vel_s <<< FRAC_BITS);
    assign ext_clamped = clamp_s(ext_sum, 0, F_HI);

    assign dx    = $signed({{(CALC_W-INPUT_WIDTH){1'b0}}, meas})
                 - $signed({{(CALC_W-INPUT_WIDTH){1'b0}}, pos});
    assign gated = (dx <= GATE_RADIUS) && (dx >= -GATE_RADIUS);

    always_ff @(posedge clk) begin
        if (reset) begin
            f   <= '0;
            vel <= '0;
        end else begin
            unique case (op)
                OP_CLEAR: begin
                    f   <= '0;
                    vel <= '0;
                end
                OP_SNAP: begin
                    f   <= meas_fx;
                    vel <= '0;
                end
                OP_FILTER: begin
                    f   <= f_filt;
                    vel <= vel_filt;
                end
                OP_EXTRAP: f <= ext_clamped[FW-1:0];
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/position_tracker.sv
// Per-frame target tracker: EOF detect, IDLE/ACQUIRE/TRACK/COAST FSM, hit/miss counters.
// Outputs and frame_tick update two cycles after EOF; no backpressure, one update per frame.
module position_tracker
    import tracker_pkg::*;
#(
    parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int FRAME_X_MAX  = 640,
    parameter int FRAME_Y_MAX  = 480,
    parameter int FRAC_BITS    = DEF_FRAC_BITS,
    parameter int SMOOTH_SHIFT = 2,
    parameter int ACQ_FRAMES   = 3,
    parameter int COAST_FRAMES = 4,
    parameter int GATE_RADIUS  = 64
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [INPUT_WIDTH-1:0] vga_x,
    input  logic [INPUT_WIDTH-1:0] vga_y,
    input  logic [INPUT_WIDTH-1:0] x_position,
    input  logic [INPUT_WIDTH-1:0] y_position,
    output logic [INPUT_WIDTH-1:0] track_x,
    output logic [INPUT_WIDTH-1:0] track_y,
    output logic                   track_valid,
    output logic                   track_locked,
    output logic                   frame_tick
);
    localparam int HC_W = $clog2(ACQ_FRAMES + 1);
    localparam int MC_W = $clog2(COAST_FRAMES + 1);
    localparam logic [INPUT_WIDTH-1:0] X_END   = INPUT_WIDTH'(FRAME_X_MAX);
    localparam logic [INPUT_WIDTH-1:0] Y_END   = INPUT_WIDTH'(FRAME_Y_MAX);
    localparam logic [HC_W-1:0]        HC_ONE  = HC_W'(1);
    localparam logic [HC_W-1:0]        HC_LAST = HC_W'(ACQ_FRAMES - 1);
    localparam logic [HC_W-1:0]        HC_FULL = HC_W'(ACQ_FRAMES);
    localparam logic [MC_W-1:0]        MC_ONE  = MC_W'(1);
    localparam logic [MC_W-1:0]        MC_LAST = MC_W'(COAST_FRAMES - 1);

    state_t          state, state_nx;
    axis_op_t        op;
    logic [HC_W-1:0] hit_cnt, hit_cnt_nx;
    logic [MC_W-1:0] miss_cnt, miss_cnt_nx;
    logic            clear, eof, eof_d;
    logic            hit, gated_hit, gate_x, gate_y;

    assign clear     = reset || !enable;
    assign eof       = (vga_x == X_END) && (vga_y == Y_END);
    assign hit       = !(((x_position == '0) && (y_position == '0))
                       || (x_position >= X_END) || (y_position >= Y_END));
    assign gated_hit = hit && gate_x && gate_y;

    always_comb begin
        state_nx    = state;
        op          = OP_HOLD;
        hit_cnt_nx  = hit_cnt;
        miss_cnt_nx = miss_cnt;
        if (eof_d) begin
            unique case (state)
                ST_IDLE: if (hit) begin
                    op         = OP_SNAP;
                    hit_cnt_nx = HC_ONE;
                    state_nx   = (ACQ_FRAMES == 1) ? ST_TRACK : ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (gated_hit) begin
                        op = OP_FILTER;
                        if (hit_cnt >= HC_LAST) begin
                            hit_cnt_nx = HC_FULL;
                            state_nx   = ST_TRACK;
                        end else begin
                            hit_cnt_nx = hit_cnt + HC_ONE;
                        end
                    end else if (hit) begin
                        op         = OP_SNAP;
                        hit_cnt_nx = HC_ONE;
                    end else begin
                        op         = OP_CLEAR;
                        hit_cnt_nx = '0;
                        state_nx   = ST_IDLE;
                    end
                end
                ST_TRACK: begin
                    if (gated_hit) begin
                        op = OP_FILTER;
                    end else if (COAST_FRAMES == 1) begin
                        op         = OP_CLEAR;
                        hit_cnt_nx = '0;
                        state_nx   = ST_IDLE;
                    end else begin
                        op          = OP_EXTRAP;
                        miss_cnt_nx = MC_ONE;
                        state_nx    = ST_COAST;
                    end
                end
                default: begin
                    if (gated_hit) begin
                        op          = OP_FILTER;
                        miss_cnt_nx = '0;
                        state_nx    = ST_TRACK;
                    end else if (miss_cnt >= MC_LAST) begin
                        op          = OP_CLEAR;
                        hit_cnt_nx  = '0;
                        miss_cnt_nx = '0;
                        state_nx    = ST_IDLE;
                    end else begin
                        op          = OP_EXTRAP;
                        miss_cnt_nx = miss_cnt + MC_ONE;
                    end
                end
            endcase
        end
    end

    // A clear landing on the eof_d cycle drops that frame's update and its tick.
    always_ff @(posedge clk) begin
        if (clear) begin
            state      <= ST_IDLE;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            eof_d      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nx;
            hit_cnt    <= hit_cnt_nx;
            miss_cnt   <= miss_cnt_nx;
            eof_d      <= eof;
            frame_tick <= eof_d;
        end
    end

    track_axis_filter #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .FRAC_BITS   (FRAC_BITS),
        .SMOOTH_SHIFT(SMOOTH_SHIFT),
        .GATE_RADIUS (GATE_RADIUS),
        .AXIS_MAX    (FRAME_X_MAX)
    ) u_axis_x (
        .clk  (clk),
        .reset(clear),
        .op   (op),
        .meas (x_position),
        .pos  (track_x),
        .gated(gate_x)
    );

    track_axis_filter #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .FRAC_BITS   (FRAC_BITS),
        .SMOOTH_SHIFT(SMOOTH_SHIFT),
        .GATE_RADIUS (GATE_RADIUS),
        .AXIS_MAX    (FRAME_Y_MAX)
    ) u_axis_y (
        .clk  (clk),
        .reset(clear),
        .op   (op),
        .meas (y_position),
        .pos  (track_y),
        .gated(gate_y)
    );

    assign track_valid  = (state == ST_TRACK) || (state == ST_COAST);
    assign track_locked = (state == ST_TRACK);

endmodule

// File: tb/tb_position_tracker.sv
// Directed-vector bench for position_tracker with a per-frame behavioural model and literal pins.
module tb_position_tracker;
    localparam int IW = 11;
    localparam int S_IDLE = 0, S_ACQ = 1, S_TRK = 2, S_CST = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, enable;
    logic [IW-1:0] vga_x, vga_y, x_position, y_position;
    logic [IW-1:0] track_x, track_y;
    logic          track_valid, track_locked, frame_tick;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 0;

    position_tracker dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .x_position  (x_position),
        .y_position  (y_position),
        .track_x     (track_x),
        .track_y     (track_y),
        .track_valid (track_valid),
        .track_locked(track_locked),
        .frame_tick  (frame_tick)
    );

    // Model: positions in 1/16 pixel units, one update per frame.
    int m_st = S_IDLE, m_fx = 0, m_fy = 0, m_vx = 0, m_vy = 0, m_hc = 0, m_mc = 0;
    bit m_pend = 0, m_tick = 0;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int ema(input int f, input int m);
        return f + ((m * 16 - f) >>> 2);
    endfunction

    function automatic int extrap(input int f, input int v, input int max);
        int t;
        t = f + v * 16;
        if (t < 0) t = 0;
        if (t > (max - 1) * 16) t = (max - 1) * 16;
        return t;
    endfunction

    task automatic m_clear();
        m_st = S_IDLE; m_fx = 0; m_fy = 0; m_vx = 0; m_vy = 0; m_hc = 0; m_mc = 0;
    endtask

    task automatic m_filter(input int mx, input int my);
        int nx, ny;
        nx = ema(m_fx, mx);
        ny = ema(m_fy, my);
        m_vx = nx / 16 - m_fx / 16;
        m_vy = ny / 16 - m_fy / 16;
        m_fx = nx;
        m_fy = ny;
    endtask

    task automatic m_extrap();
        m_fx = extrap(m_fx, m_vx, 640);
        m_fy = extrap(m_fy, m_vy, 480);
    endtask

    task automatic m_snap(input int mx, input int my);
        m_fx = mx * 16; m_fy = my * 16; m_vx = 0; m_vy = 0; m_hc = 1;
    endtask

    task automatic model_frame(input int mx, input int my);
        bit miss, gated;
        miss  = (mx == 0 && my == 0) || mx >= 640 || my >= 480;
        gated = !miss && iabs(mx - m_fx / 16) <= 64 && iabs(my - m_fy / 16) <= 64;
        case (m_st)
            S_IDLE: if (!miss) begin
                m_snap(mx, my);
                m_st = (m_hc >= 3) ? S_TRK : S_ACQ;
            end
            S_ACQ: begin
                if (gated) begin
                    m_filter(mx, my);
                    m_hc++;
                    if (m_hc >= 3) m_st = S_TRK;
                end else if (!miss) m_snap(mx, my);
                else m_clear();
            end
            S_TRK: begin
                if (gated) m_filter(mx, my);
                else begin
                    m_mc = 1;
                    m_st = S_CST;
                    if (m_mc >= 4) m_clear(); else m_extrap();
                end
            end
            default: begin
                if (gated) begin
                    m_filter(mx, my);
                    m_mc = 0;
                    m_st = S_TRK;
                end else begin
                    m_mc++;
                    if (m_mc >= 4) m_clear(); else m_extrap();
                end
            end
        endcase
    endtask

    always @(posedge clk) begin
        if (reset || !enable) begin
            m_clear();
            m_pend = 0;
            m_tick = 0;
        end else begin
            m_tick = m_pend;
            if (m_pend) model_frame(int'(x_position), int'(y_position));
            m_pend = (vga_x == 11'd640) && (vga_y == 11'd480);
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Every-cycle comparison of all outputs against the model.
    initial begin
        logic [2*IW+2:0] act, exp_v;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                act   = {track_x, track_y, track_valid, track_locked, frame_tick};
                exp_v = {IW'(m_fx / 16), IW'(m_fy / 16), m_st == S_TRK || m_st == S_CST,
                         m_st == S_TRK, m_tick};
                n_checks++;
                if (act === exp_v) n_pass++;
                else $display("FAIL model_cmp @%0t: got x=%0d y=%0d v=%b l=%b t=%b, expected x=%0d y=%0d v=%b l=%b t=%b",
                              $time, track_x, track_y, track_valid, track_locked, frame_tick,
                              exp_v[2*IW+2:IW+3], exp_v[IW+2:3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
    end

    task automatic frame(input int mx, input int my);
        @(negedge clk);
        x_position = IW'(mx);
        y_position = IW'(my);
        vga_x = 11'd640;
        vga_y = 11'd480;
        @(negedge clk);
        vga_x = '0;
        vga_y = '0;
        check("tick_early", frame_tick, 0);
        @(negedge clk);
        check("tick_eof2", frame_tick, 1);
        @(negedge clk);
        check("tick_once", frame_tick, 0);
    endtask

    task automatic expect_out(input string name, input int x, input int y, input int v, input int l);
        check({name, ".x"}, track_x, x);
        check({name, ".y"}, track_y, y);
        check({name, ".valid"}, track_valid, v);
        check({name, ".locked"}, track_locked, l);
    endtask

    task automatic lock_at(input int x, input int y);
        for (int i = 0; i < 3; i++) frame(x, y);
    endtask

    task automatic aborted_frame(input bit use_reset);
        @(negedge clk);
        x_position = 11'd50;
        y_position = 11'd60;
        vga_x = 11'd640;
        vga_y = 11'd480;
        @(negedge clk);
        vga_x = '0;
        vga_y = '0;
        if (use_reset) reset = 1'b1; else enable = 1'b0;
        @(negedge clk);
        check(use_reset ? "abort_rst_tick" : "abort_en_tick", frame_tick, 0);
        expect_out(use_reset ? "abort_rst" : "abort_en", 0, 0, 0, 0);
        reset  = 1'b0;
        enable = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; enable = 1'b1;
        vga_x = '0; vga_y = '0; x_position = '0; y_position = '0;
        @(posedge clk);
        cmp_en = 1;
        @(negedge clk);
        @(negedge clk);
        expect_out("reset", 0, 0, 0, 0);
        check("reset.tick", frame_tick, 0);
        reset = 1'b0;

        frame(0, 0);
        frame(0, 0);
        expect_out("idle_zero", 0, 0, 0, 0);

        frame(100, 200);
        check("acq1.valid", track_valid, 0);
        frame(100, 200);
        check("acq2.valid", track_valid, 0);
        frame(100, 200);
        expect_out("locked100", 100, 200, 1, 1);

        frame(140, 200);
        expect_out("ema110", 110, 200, 1, 1);
        frame(0, 0);
        expect_out("coast120", 120, 200, 1, 0);
        frame(0, 0);
        check("coast130.x", track_x, 130);
        frame(0, 0);
        check("coast140.x", track_x, 140);
        frame(0, 0);
        expect_out("drop", 0, 0, 0, 0);

        lock_at(100, 200);
        frame(140, 200);
        frame(140, 200);
        expect_out("ema117", 117, 200, 1, 1);

        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        expect_out("en_drop", 0, 0, 0, 0);
        @(negedge clk);
        enable = 1'b1;

        lock_at(100, 200);
        frame(300, 200);
        expect_out("ungated_coast", 100, 200, 1, 0);
        frame(105, 200);
        expect_out("reacquire", 101, 200, 1, 1);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        lock_at(600, 200);
        frame(639, 200);
        check("hi_ema1.x", track_x, 609);
        frame(639, 200);
        check("hi_ema2.x", track_x, 617);
        frame(0, 0);
        check("hi_c1.x", track_x, 625);
        frame(0, 0);
        check("hi_c2.x", track_x, 633);
        frame(0, 0);
        expect_out("hi_clamp", 639, 200, 1, 0);
        frame(0, 0);
        expect_out("hi_drop", 0, 0, 0, 0);

        lock_at(63, 200);
        frame(0, 200);
        expect_out("lo_ema", 47, 200, 1, 1);
        frame(0, 0);
        check("lo_c1.x", track_x, 31);
        frame(0, 0);
        check("lo_c2.x", track_x, 15);
        frame(0, 0);
        expect_out("lo_clamp", 0, 200, 1, 0);
        frame(0, 0);
        check("lo_drop.valid", track_valid, 0);

        frame(50, 60);
        expect_out("acq_snap", 50, 60, 0, 0);
        frame(300, 60);
        expect_out("acq_resnap", 300, 60, 0, 0);
        frame(0, 0);
        expect_out("acq_miss", 0, 0, 0, 0);

        frame(50, 60);
        aborted_frame(1'b1);
        frame(50, 60);
        aborted_frame(1'b0);
        frame(0, 0);
        expect_out("final_idle", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/position_tracker.md
# position_tracker

Per-frame target tracker directly downstream of the centroid measurement stage. Once per video frame it samples the measured (x,y) centroid, gates it against the current track, and smooths it with an exponential moving average. A four-state machine (IDLE/ACQUIRE/TRACK/COAST) extrapolates through missed frames and publishes a stable track position plus status flags to the overlay/servo logic.

## Interface
- INPUT_WIDTH, 11, width of pixel coordinates
- FRAME_X_MAX, 640, end-of-frame x coordinate; valid pixels are 0..FRAME_X_MAX-1
- FRAME_Y_MAX, 480, end-of-frame y coordinate; valid lines are 0..FRAME_Y_MAX-1
- FRAC_BITS, 4, fractional bits of the internal filter state
- SMOOTH_SHIFT, 2, EMA gain 2^-SMOOTH_SHIFT; 0 = no smoothing
- ACQ_FRAMES, 3, consecutive gated hits needed to lock (≥1)
- COAST_FRAMES, 4, consecutive misses tolerated before dropping (≥1)
- GATE_RADIUS, 64, max per-axis |meas − track| accepted as a hit

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset
- enable  in  1  low = hold in reset-equivalent state
- vga_x, vga_y  in  INPUT_WIDTH  raster counters, shared with the measurement stage
- x_position, y_position  in  INPUT_WIDTH  measured centroid, valid from the cycle after end-of-frame
- track_x, track_y  out  INPUT_WIDTH  tracked position, integer part of filter state
- track_valid  out  1  state is TRACK or COAST
- track_locked  out  1  state is TRACK
- frame_tick  out  1  one-cycle pulse when outputs update

## Operation
- End-of-frame (EOF): vga_x==FRAME_X_MAX and vga_y==FRAME_Y_MAX. Registered to eof_d; the update is evaluated in the eof_d cycle.
- Miss: measurement is (0,0), x≥FRAME_X_MAX, or y≥FRAME_Y_MAX. Hit: not a miss. Gated hit: a hit with |meas−track| ≤ GATE_RADIUS on both axes.
- Filter per axis: state f is unsigned, INPUT_WIDTH+FRAC_BITS bits. diff = (meas<<FRAC_BITS) − f, signed, one extra bit. f += diff >>> SMOOTH_SHIFT (arithmetic shift). Snap: f = meas<<FRAC_BITS, vel = 0.
- Velocity vel is signed, INPUT_WIDTH+1 bits. On a filtered update: vel = new int(f) − old int(f).
- Extrapolate: f += vel<<FRAC_BITS, clamped to [0, (MAX−1)<<FRAC_BITS].
- IDLE: hit → snap, hit_cnt=1, go to ACQUIRE (go to TRACK if ACQ_FRAMES==1). Miss → stay.
- ACQUIRE: gated hit → filter, hit_cnt+1; if it reaches ACQ_FRAMES → TRACK. Ungated hit → snap, hit_cnt=1, stay. Miss → IDLE; f and vel cleared.
- TRACK: gated hit → filter, stay. Miss or ungated hit → extrapolate, miss_cnt=1, go to COAST (go to IDLE if COAST_FRAMES==1).
- COAST: gated hit → filter, miss_cnt=0, go to TRACK. Otherwise miss_cnt+1; if it reaches COAST_FRAMES → IDLE with f and vel cleared, else extrapolate.
- Gating always compares against int(f) before the update.

## Timing
- Reset: all outputs 0, state IDLE, all counters, f and vel 0. Reset has priority over enable.
- enable low: same effect as reset on the next edge. Resuming enable begins at the next EOF.
- Latency: EOF at cycle N; sampling at N+1; outputs and frame_tick visible at N+2. Outputs hold between ticks.
- frame_tick pulses every frame, including IDLE frames.
- A reset or enable drop coinciding with eof_d aborts the update; no tick is issued.
- No counter wraps: hit_cnt and miss_cnt saturate at their thresholds.

## Structure
- Package tracker_pkg: state enum (IDLE, ACQUIRE, TRACK, COAST), fixed-point width localparams, and a clamp function.
- Sub-module track_axis_filter, instantiated per axis: filter state, velocity, gate compare, and clamp. Per-axis MAX is passed as a parameter. The top level holds the FSM, counters and EOF detection.

## Test plan
All scenarios use default parameters.
- Reset then (0,0) every frame → track outputs 0, valid=0, tick each frame at EOF+2.
- Three frames of (100,200) → valid stays 0 after frames 1–2. After frame 3: valid=1, locked=1, track=(100,200).
- Locked at (100,200), then meas (140,200) → track_x=110, vel_x=10. Meas 140 again → track_x=117.
- Locked at x=110 with vel=+10, then misses → 120, locked=0, valid=1, then 130, 140. Fourth miss → IDLE, valid=0, track=(0,0).
- Locked at x=100, meas x=300 (outside gate) → treated as miss, COAST, extrapolated. Next meas x=105 → back to TRACK.
- Coasting at x=635 with vel=+10 → track_x clamps to 639. Drop enable mid-TRACK → next edge all outputs 0, state IDLE.
